// File: rtl/supervisor_pkg.sv
// supervisor_pkg: shared FSM state type and counter width for the test supervisor
package supervisor_pkg;
   localparam int CYCLE_W = 32;
   typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;
endpackage

// File: rtl/test_supervisor_if.sv
// test_supervisor_if: link between the supervisor and the bench it supervises
//   t_fail, t_finish : bench -> supervisor status flags
//   t_reset          : supervisor -> bench reset
//   done, pass, fail, timeout, cycles : registered verdict outputs
interface test_supervisor_if;
   import supervisor_pkg::*;
   logic t_fail, t_finish, t_reset, done, pass, fail, timeout;
   logic [CYCLE_W-1:0] cycles;
   modport master(input t_fail, t_finish, output t_reset, done, pass, fail, timeout, cycles);
   modport slave(output t_fail, t_finish, input t_reset, done, pass, fail, timeout, cycles);
endinterface

// File: rtl/sup_counter.sv
// sup_counter: W-bit up counter with synchronous clear, enable and terminal compare
//   clock  : rising-edge clock
//   clr_i  : synchronous clear (wins over en_i)
//   en_i   : count enable
//   term_i : terminal value; hit_o is high while the count equals it
//   cnt_o  : registered count
module sup_counter
   import supervisor_pkg::*;
#(
   parameter int W = CYCLE_W
) (
   input  logic         clock,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] term_i,
   output logic [W-1:0] cnt_o,
   output logic         hit_o
);
   logic [W-1:0] cnt_q;
   always_ff @(posedge clock)
      cnt_q <= clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
   assign cnt_o = cnt_q;
   assign hit_o = cnt_q == term_i;
endmodule

// File: rtl/test_supervisor.sv
// test_supervisor: holds a bench in reset, runs it, and latches a pass/fail/timeout verdict
//   clock, reset : rising-edge clock, synchronous active-high reset
//   sup          : master side of test_supervisor_if (bench flags in, reset and verdict out)
module test_supervisor
   import supervisor_pkg::*;
#(
   parameter int RESET_CYCLES = 4,
   parameter int TIMEOUT      = 1024
) (
   input logic              clock,
   input logic              reset,
   test_supervisor_if.master sup
);
   state_t             state_q;
   logic               t_reset_q, done_q, pass_q, fail_q, timeout_q, fail_seen_q;
   logic [CYCLE_W-1:0] hold_cnt;
   logic               hold_hit, run_hit, fail_now, unused_hold;

   // Only the terminal compare of the hold count matters.
   assign unused_hold = ^hold_cnt;
   assign fail_now    = fail_seen_q | sup.t_fail;

   sup_counter #(.W(CYCLE_W)) u_hold (
      .clock (clock),
      .clr_i (reset),
      .en_i  (state_q == HOLD),
      .term_i(CYCLE_W'(RESET_CYCLES - 1)),
      .cnt_o (hold_cnt),
      .hit_o (hold_hit)
   );

   // The RUN count register is the cycles output; it stops counting outside RUN.
   sup_counter #(.W(CYCLE_W)) u_run (
      .clock (clock),
      .clr_i (reset),
      .en_i  (state_q == RUN),
      .term_i(CYCLE_W'(TIMEOUT - 1)),
      .cnt_o (sup.cycles),
      .hit_o (run_hit)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= HOLD;
         t_reset_q   <= 1'b1;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         timeout_q   <= 1'b0;
         fail_seen_q <= 1'b0;
      end else begin
         case (state_q)
            HOLD: if (hold_hit) begin
               state_q   <= RUN;
               t_reset_q <= 1'b0;
            end
            RUN: begin
               fail_seen_q <= fail_now;
               // A finish on the last allowed cycle beats the timeout.
               if (sup.t_finish) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  pass_q  <= !fail_now;
                  fail_q  <= fail_now;
               end else if (run_hit) begin
                  state_q   <= DONE;
                  done_q    <= 1'b1;
                  fail_q    <= 1'b1;
                  timeout_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign sup.t_reset = t_reset_q;
   assign sup.done    = done_q;
   assign sup.pass    = pass_q;
   assign sup.fail    = fail_q;
   assign sup.timeout = timeout_q;
endmodule

// File: doc/test_supervisor.md
TEST_SUPERVISOR -- requirements
Module: test_supervisor

Interface
REQ-001 SHALL take parameter RESET_CYCLES, default 4, number of cycles the bench reset is held (range 1..255).
REQ-002 SHALL take parameter TIMEOUT, default 1024, maximum number of RUN cycles before the test is declared hung (range 1..2^31-1).
REQ-003 SHALL have port clock, input, 1, system clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port t_fail, input, 1, fail flag from the bench under supervision.
REQ-006 SHALL have port t_finish, input, 1, finish flag from the bench under supervision.
REQ-007 SHALL have port t_reset, output, 1, reset driven into the bench under supervision.
REQ-008 SHALL have port done, output, 1, verdict valid; sticky.
REQ-009 SHALL have port pass, output, 1, test completed with no failure.
REQ-010 SHALL have port fail, output, 1, test failed or timed out.
REQ-011 SHALL have port timeout, output, 1, test hit TIMEOUT without finishing.
REQ-012 SHALL have port cycles, output, 32, number of RUN cycles elapsed; frozen at done.

Function
REQ-013 SHALL implement FSM states HOLD, RUN, DONE.
REQ-014 HOLD SHALL drive t_reset=1 for exactly RESET_CYCLES cycles, then go to RUN.
REQ-015 RUN SHALL drive t_reset=0 and increment cycles by 1 each cycle.
REQ-016 RUN SHALL set an internal sticky fail_seen on any cycle with t_fail=1.
REQ-017 t_fail and t_finish SHALL be ignored in HOLD and in DONE.
REQ-018 RUN with t_finish=1 SHALL go to DONE next cycle, with pass=!(fail_seen|t_fail) and fail=its complement.
REQ-019 Simultaneous t_fail=1 and t_finish=1 in the same RUN cycle SHALL yield fail=1, pass=0.
REQ-020 RUN with cycles==TIMEOUT-1 and t_finish=0 SHALL go to DONE with timeout=1, fail=1, pass=0.
REQ-021 t_finish=1 on the timeout cycle SHALL take priority: timeout=0 and the verdict follows REQ-018.
REQ-022 DONE SHALL hold done, pass, fail, timeout and cycles constant and keep t_reset=0 until reset.
REQ-023 At all times, pass and fail SHALL be mutually exclusive, and both SHALL be 0 while done=0.
REQ-024 cycles SHALL NOT wrap: TIMEOUT bounds it below 2^32.

Reset
REQ-025 reset=1 SHALL force state HOLD, with HOLD counter=0, cycles=0, fail_seen=0, done=0, pass=0, fail=0, timeout=0 and t_reset=1.
REQ-026 reset asserted mid-RUN or in DONE SHALL abort the test and restart HOLD, with t_reset=1 from the next cycle; no verdict is retained.

Structure
REQ-027 Shared package supervisor_pkg SHALL hold the state enum (HOLD, RUN, DONE) and the localparam CYCLE_W=32.
REQ-028 One sub-module sup_counter (CYCLE_W-wide counter with clear, enable and terminal-compare output) SHALL be instantiated twice: once for the HOLD count and once for the RUN count.
REQ-029 All outputs SHALL be registered; there SHALL be no combinational path from t_fail or t_finish to any output.

Verification
REQ-030 Clean run: RESET_CYCLES=4; t_finish=1 at RUN cycle 4 with t_fail=0 throughout -> t_reset high 4 cycles; done=1, pass=1, fail=0, timeout=0, cycles=5.
REQ-031 Early fail: t_fail pulse at RUN cycle 1; t_finish at cycle 3 -> done=1, pass=0, fail=1, timeout=0.
REQ-032 Simultaneous: t_fail=1 and t_finish=1 together at cycle 2 -> fail=1, pass=0.
REQ-033 Timeout: TIMEOUT=8, t_finish never asserted -> done=1 after 8 RUN cycles, timeout=1, fail=1, cycles=8.
REQ-034 Finish on the timeout cycle: TIMEOUT=8, t_finish at cycle 7 -> timeout=0, pass=1.
REQ-035 Reset mid-RUN at cycle 3, then clean finish -> t_reset reasserted 4 cycles, cycles restarts at 0, final pass=1; a t_fail pulse during HOLD -> pass=1.
